// File: rtl/regfile_scoreboard.sv
// Register file with two registered read ports, one write port and x0 tied to zero.
// A per-register busy scoreboard with a running count flags decode hazards.
module regfile_scoreboard #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned NAME_BITS = 5,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [NAME_BITS-1:0] ws_i,
  input  logic [REG_WIDTH-1:0] wd_i,
  input  logic                 re_i,
  input  logic [NAME_BITS-1:0] rs1_i,
  input  logic [NAME_BITS-1:0] rs2_i,
  output logic [REG_WIDTH-1:0] rd1_o,
  output logic [REG_WIDTH-1:0] rd2_o,
  output logic                 rd1_pend_o,
  output logic                 rd2_pend_o,
  input  logic                 iss_valid_i,
  input  logic [NAME_BITS-1:0] iss_rd_i,
  input  logic                 flush_i,
  output logic [NAME_BITS:0]   busy_cnt_o
);

  localparam int unsigned NUM_REGS = 1 << NAME_BITS;
  localparam int unsigned CW       = NAME_BITS + 1;

  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
  logic [REG_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic                 pend1_q, pend1_d, pend2_q, pend2_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic wrValid, issValid, setNew, clrEff;
  logic hit1, hit2;

  assign wrValid  = we_i && (ws_i != '0);
  assign issValid = iss_valid_i && (iss_rd_i != '0);

  // A read that coincides with a write to the same register only sees the
  // new data (and loses its hazard) when forwarding is enabled.
  assign hit1 = BYPASS && wrValid && (ws_i == rs1_i);
  assign hit2 = BYPASS && wrValid && (ws_i == rs2_i);

  always_comb begin
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    if (re_i) begin
      if (rs1_i == '0) begin
        rd1_d   = '0;
        pend1_d = 1'b0;
      end else begin
        rd1_d   = hit1 ? wd_i : regs_q[rs1_i];
        pend1_d = busy_q[rs1_i] && !hit1;
      end
      if (rs2_i == '0) begin
        rd2_d   = '0;
        pend2_d = 1'b0;
      end else begin
        rd2_d   = hit2 ? wd_i : regs_q[rs2_i];
        pend2_d = busy_q[rs2_i] && !hit2;
      end
    end
  end

  // Issue beats a same-edge writeback clear of the same index, so a clear
  // only reduces the count when it actually turns a set bit off.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    setNew = issValid && !busy_q[iss_rd_i];
    clrEff = wrValid && busy_q[ws_i] && !(issValid && (iss_rd_i == ws_i));
    if (flush_i) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (wrValid)  busy_d[ws_i]     = 1'b0;
      if (issValid) busy_d[iss_rd_i] = 1'b1;
      cnt_d = cnt_q + CW'(setNew) - CW'(clrEff);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wrValid) begin
      regs_q[ws_i] <= wd_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd1_q   <= '0;
      rd2_q   <= '0;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd1_o      = rd1_q;
  assign rd2_o      = rd2_q;
  assign rd1_pend_o = pend1_q;
  assign rd2_pend_o = pend2_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one forwarding instance and one
// non-forwarding instance share every input so same-edge behaviour can be contrasted.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0, issValid = 1'b0, flush = 1'b0;
  logic [4:0]  ws = '0, rs1 = '0, rs2 = '0, issRd = '0;
  logic [31:0] wd = '0;

  logic [31:0] rd1, rd2, rd1Nb, rd2Nb;
  logic        pend1, pend2, pend1Nb, pend2Nb;
  logic [5:0]  busyCnt, busyCntNb;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.REG_WIDTH(32), .NAME_BITS(5), .BYPASS(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .ws_i(ws), .wd_i(wd), .re_i(re),
    .rs1_i(rs1), .rs2_i(rs2), .rd1_o(rd1), .rd2_o(rd2),
    .rd1_pend_o(pend1), .rd2_pend_o(pend2), .iss_valid_i(issValid),
    .iss_rd_i(issRd), .flush_i(flush), .busy_cnt_o(busyCnt)
  );

  regfile_scoreboard #(.REG_WIDTH(32), .NAME_BITS(5), .BYPASS(1'b0)) dutNb (
    .clk_i(clk), .rst_i(rst), .we_i(we), .ws_i(ws), .wd_i(wd), .re_i(re),
    .rs1_i(rs1), .rs2_i(rs2), .rd1_o(rd1Nb), .rd2_o(rd2Nb),
    .rd1_pend_o(pend1Nb), .rd2_pend_o(pend2Nb), .iss_valid_i(issValid),
    .iss_rd_i(issRd), .flush_i(flush), .busy_cnt_o(busyCntNb)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one edge's worth of inputs, clocks it in, then returns 1 ns after
  // the edge with all strobes dropped so outputs can be sampled safely.
  task automatic applyStimulus(input logic w, input logic [4:0] wsel,
                               input logic [31:0] wdat, input logic r,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic iv, input logic [4:0] ir,
                               input logic fl);
    we = w; ws = wsel; wd = wdat; re = r; rs1 = s1; rs2 = s2;
    issValid = iv; issRd = ir; flush = fl;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; issValid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #2;
    checkOutput("resetRd1", rd1, 32'h0);
    checkOutput("resetCnt", {26'd0, busyCnt}, 32'd0);
    #6 rst = 1'b0;

    // Reads after reset
    applyStimulus(0, 0, 0, 1, 5'd5, 5'd31, 0, 0, 0);
    checkOutput("t1Rd1", rd1, 32'h0);
    checkOutput("t1Rd2", rd2, 32'h0);
    checkOutput("t1Pend1", {31'd0, pend1}, 32'd0);
    checkOutput("t1Pend2", {31'd0, pend2}, 32'd0);
    checkOutput("t1Cnt", {26'd0, busyCnt}, 32'd0);

    // Basic write/read and x0
    applyStimulus(1, 5'd1, 32'h1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd1, 5'd0, 0, 0, 0);
    checkOutput("t2Rd1", rd1, 32'h1);
    checkOutput("t2Rd2", rd2, 32'h0);
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0);
    checkOutput("t2Hold", rd1, 32'h1);
    applyStimulus(1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd1, 0, 0, 0);
    checkOutput("t2X0", rd1, 32'h0);
    checkOutput("t2Rd2Reg1", rd2, 32'h1);

    // Same-edge write and read: forwarding vs pre-write value
    applyStimulus(1, 5'd7, 32'h11, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd7, 32'hA5, 1, 5'd7, 5'd7, 0, 0, 0);
    checkOutput("t3Byp", rd1, 32'hA5);
    checkOutput("t3NoByp", rd1Nb, 32'h11);
    applyStimulus(0, 0, 0, 1, 5'd7, 5'd0, 0, 0, 0);
    checkOutput("t3NoBypLater", rd1Nb, 32'hA5);

    // Scoreboard set, hazard flag, writeback clear
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd4, 0);
    checkOutput("t4Cnt2", {26'd0, busyCnt}, 32'd2);
    applyStimulus(0, 0, 0, 1, 5'd3, 5'd4, 0, 0, 0);
    checkOutput("t4Pend1", {31'd0, pend1}, 32'd1);
    checkOutput("t4Pend2", {31'd0, pend2}, 32'd1);
    applyStimulus(1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0);
    checkOutput("t4Cnt1", {26'd0, busyCnt}, 32'd1);
    applyStimulus(1, 5'd4, 32'h44, 1, 5'd4, 5'd3, 1, 5'd4, 0);
    checkOutput("t4IssWins", {26'd0, busyCnt}, 32'd1);
    checkOutput("t4PendByp", {31'd0, pend1}, 32'd0);
    checkOutput("t4PendNoByp", {31'd0, pend1Nb}, 32'd1);
    checkOutput("t4Rd1NoByp", rd1Nb, 32'h0);
    checkOutput("t4Pend2Clear", {31'd0, pend2}, 32'd0);
    applyStimulus(0, 0, 0, 1, 5'd4, 5'd0, 0, 0, 0);
    checkOutput("t4StillBusy", {31'd0, pend1}, 32'd1);
    checkOutput("t4Rd1", rd1, 32'h44);

    // Re-issue, x0 issue, flush with simultaneous issue
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd3, 0);
    checkOutput("t5Cnt3", {26'd0, busyCnt}, 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0, 0);
    checkOutput("t5IssX0", {26'd0, busyCnt}, 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd6, 1);
    checkOutput("t5Flush", {26'd0, busyCnt}, 32'd0);
    applyStimulus(0, 0, 0, 1, 5'd6, 5'd4, 0, 0, 0);
    checkOutput("t5Pend6", {31'd0, pend1}, 32'd0);
    checkOutput("t5Pend4", {31'd0, pend2}, 32'd0);

    // Clear of idle register, and set+clear on different indices
    applyStimulus(1, 5'd9, 32'h9, 0, 0, 0, 0, 0, 0);
    checkOutput("t5ClrIdle", {26'd0, busyCnt}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd8, 0);
    applyStimulus(1, 5'd8, 32'h8, 0, 0, 0, 1, 5'd10, 0);
    checkOutput("t5NetZero", {26'd0, busyCnt}, 32'd1);
    applyStimulus(0, 0, 0, 1, 5'd8, 5'd10, 0, 0, 0);
    checkOutput("t5Pend8", {31'd0, pend1}, 32'd0);
    checkOutput("t5Pend10", {31'd0, pend2}, 32'd1);

    // Asynchronous reset between read edges
    applyStimulus(1, 5'd2, 32'h1234, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd2, 5'd0, 0, 0, 0);
    checkOutput("t6Before", rd1, 32'h1234);
    #1 rst = 1'b1;
    #1;
    checkOutput("t6AsyncRd1", rd1, 32'h0);
    checkOutput("t6AsyncCnt", {26'd0, busyCnt}, 32'd0);
    #1 rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 5'd2, 5'd7, 0, 0, 0);
    checkOutput("t6Reg2", rd1, 32'h0);
    checkOutput("t6Reg7", rd2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
